float16_adder_arbiter: RTL and testbench
========================================

// Module: float16_adder_arbiter
// PURPOSE
//   Shares one float16 adder among NUM_REQ requesters. The adder has no stall and registers both its inputs and its output.
//   - Each cycle, picks at most one valid requester using round-robin arbitration.
//   - Drives the chosen requester's operands to the adder.
//   - Tracks each issued operation through an ADD_LAT-deep tag pipeline.
//   - Returns the sum to the originating requester exactly ADD_LAT cycles after issue.
// PARAMETERS
//   NUM_REQ    4    number of requesters (2..8)
//   ADD_LAT    2    cycles from operand issue to valid add_result (1 input reg + 1 output reg)
//   FLOAT_LEN  16   operand/result width
//   CNT_W      16   width of issue counter
// PORTS
//   clk          in   1                  clock, all state on posedge
//   rst_n        in   1                  asynchronous active-low reset
//   en           in   1                  1 = arbitration allowed; 0 = no new grants
//   req_valid    in   NUM_REQ            requester i has an operand pair pending
//   req_a        in   NUM_REQ*FLOAT_LEN  operand a, requester i at [i*16 +: 16]
//   req_b        in   NUM_REQ*FLOAT_LEN  operand b, same packing
//   req_ready    out  NUM_REQ            one-hot grant; transfer when valid&ready
//   add_a        out  FLOAT_LEN          to adder input a
//   add_b        out  FLOAT_LEN          to adder input b
//   add_result   in   FLOAT_LEN          from adder result
//   rsp_valid    out  NUM_REQ            one-hot, 1-cycle pulse: rsp_data belongs to requester i
//   rsp_data     out  FLOAT_LEN          = add_result (combinational pass-through)
//   busy         out  1                  1 while any operation is in flight
//   issue_cnt    out  CNT_W              total transfers since reset
// BEHAVIOUR
//   - Reset values (asynchronous):
//     - rr_ptr=0, tag pipeline all invalid, issue_cnt=0.
//     - This gives rsp_valid=0 and busy=0.
//     - req_ready=0 and add_a/add_b=0 while no request is present.
//   - Arbitration (combinational):
//     - Search starts at index rr_ptr and wraps modulo NUM_REQ.
//     - The first i with req_valid[i] gets req_ready[i]=1.
//     - If en=0 or no req_valid is set, req_ready is all zeros.
//     - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
//   - Operands: add_a/add_b = granted req_a/req_b. With no grant they are 16'h0000 (the adder computes 0+0; the result is discarded).
//   - rr_ptr update on posedge:
//     - If a grant was made to i, rr_ptr <= (i+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
//     - Otherwise rr_ptr holds.
//   - Tag pipeline:
//     - ADD_LAT stages of {vld, idx[$clog2(NUM_REQ)-1:0]}.
//     - Stage0 <= {grant, granted idx}; stage k <= stage k-1.
//     - Final stage drives rsp_valid[idx] = vld.
//     - A transfer in cycle t gives a rsp_valid pulse in cycle t+ADD_LAT.
//     - Back-to-back issues give back-to-back responses, in issue order.
//   - Throughput: one issue per cycle, sustained. Responses have no backpressure; requesters must accept on the pulse.
//   - busy = OR of all tag-stage vld bits.
//   - issue_cnt increments by 1 on each transfer and wraps 2^CNT_W-1 -> 0.
//   - en deasserted mid-stream: in-flight operations still complete and respond. Only new grants stop.
//   - A requester dropping req_valid without a grant is legal; nothing is issued for it.
//   - Asynchronous reset mid-operation: all tags are cleared immediately and no rsp_valid appears for in-flight operations. The adder shares rst_n.
//   - The block never inspects data. NaN/Inf/rounding are handled entirely by the adder.
// TESTING
//   - Single request:
//     - Stimulus: req_valid=4'b0001, a=3C00, b=3C00, en=1, one cycle.
//     - Required: req_ready=0001 that cycle; 2 cycles later rsp_valid=0001 and rsp_data=4000; issue_cnt=1.
//   - Contention:
//     - Stimulus: req_valid=0101 held, rr_ptr=0.
//     - Required: grants go 0,2,0,2...; each rsp_valid matches its grant delayed 2 cycles.
//     - Required: rsp_data for req2 (a=3C00, b=4000) = 4200.
//   - Full load:
//     - Stimulus: all four valid for 8 cycles.
//     - Required: grant order 0,1,2,3,0,1,2,3; busy=1 from cycle 1 until 2 cycles after the last issue; issue_cnt=8.
//   - Enable gating:
//     - Stimulus: en drops after 3 issues.
//     - Required: req_ready=0 immediately; the 3 responses still arrive; busy then falls to 0.
//   - Reset mid-flight:
//     - Stimulus: issue 2 ops, assert rst_n=0 one cycle later.
//     - Required: rsp_valid stays 0, busy=0, issue_cnt=0.
//     - Required after release: first grant goes to req0.
//   - Special values:
//     - Stimulus: req1 a=7C00, b=FC00.
//     - Required: rsp_valid=0010, rsp_data=7E00.
//     - Stimulus: counter preset near wrap.
//     - Required: issue_cnt FFFF -> 0000.

Source files
------------

// File: rtl/float16_adder_arbiter.sv
// Round-robin share of one float16 adder (2-stage, no stall) among NUM_REQ requesters; sum returns ADD_LAT cycles after issue.
// Grant is combinational on req_valid; responses carry no backpressure and must be taken on the rsp_valid pulse.
module float16_adder_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADD_LAT   = 2,
    parameter int FLOAT_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*FLOAT_LEN-1:0]   req_a,
    input  logic [NUM_REQ*FLOAT_LEN-1:0]   req_b,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [FLOAT_LEN-1:0]           add_a,
    output logic [FLOAT_LEN-1:0]           add_b,
    input  logic [FLOAT_LEN-1:0]           add_result,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [FLOAT_LEN-1:0]           rsp_data,
    output logic                           busy,
    output logic [CNT_W-1:0]               issue_cnt
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic             grant;
    logic [IDX_W-1:0] grant_idx;
    logic [ADD_LAT-1:0] tag_vld;
    logic [IDX_W-1:0]   tag_idx [ADD_LAT];

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        int               j;
        logic [IDX_W-1:0] cand;
        grant     = 1'b0;
        grant_idx = '0;
        j         = 0;
        cand      = '0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j = int'(rr_ptr) + k;
                if (j >= NUM_REQ) j = j - NUM_REQ;
                cand = IDX_W'(j);
                if (!grant && req_valid[cand]) begin
                    grant     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && grant_idx == IDX_W'(i)) begin
                req_ready[i] = 1'b1;
                add_a        = req_a[i*FLOAT_LEN +: FLOAT_LEN];
                add_b        = req_b[i*FLOAT_LEN +: FLOAT_LEN];
            end
            if (tag_vld[ADD_LAT-1] && tag_idx[ADD_LAT-1] == IDX_W'(i)) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

    assign rsp_data = add_result;
    assign busy     = |tag_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            issue_cnt <= '0;
        end else if (grant) begin
            rr_ptr    <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            issue_cnt <= issue_cnt + CNT_W'(1);
        end
    end

    // Tag pipeline mirrors the adder's register stages so the result is routed back to its owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int k = 0; k < ADD_LAT; k++) tag_idx[k] <= '0;
        end else begin
            tag_vld[0] <= grant;
            tag_idx[0] <= grant_idx;
            for (int k = 1; k < ADD_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
        end
    end
endmodule

// File: tb/tb_float16_adder_arbiter.sv
// Bench for float16_adder_arbiter: 2-stage adder stand-in, round-robin reference model, scoreboard on responses.
module tb_float16_adder_arbiter;
    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  req_valid;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_ready, rsp_valid;
    logic [15:0] add_a, add_b, add_result, rsp_data;
    logic        busy;
    logic [15:0] issue_cnt;
    // Narrow-counter instance sharing the same inputs exercises counter wrap quickly
    logic [3:0]  req_ready4, rsp_valid4;
    logic [15:0] add_a4, add_b4, rsp_data4;
    logic        busy4;
    logic [3:0]  issue_cnt4;

    float16_adder_arbiter dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .issue_cnt(issue_cnt)
    );

    float16_adder_arbiter #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready4), .add_a(add_a4), .add_b(add_b4), .add_result(add_result),
        .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .busy(busy4), .issue_cnt(issue_cnt4)
    );

    always #5 clk = ~clk;

    // Known float16 sums; other operand pairs get an arbitrary deterministic stand-in result
    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3C003C00: return 16'h4000;
            32'h3C004000: return 16'h4200;
            32'h40003C00: return 16'h4200;
            32'h40004000: return 16'h4400;
            32'h38003800: return 16'h3C00;
            32'h7C00FC00: return 16'h7E00;
            32'hC0004000: return 16'h0000;
            32'h00000000: return 16'h0000;
            default:      return a ^ b ^ 16'h1234;
        endcase
    endfunction

    logic [15:0] a_r, b_r, res_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0; b_r <= '0; res_r <= '0;
        end else begin
            a_r <= add_a; b_r <= add_b; res_r <= fadd(a_r, b_r);
        end
    end
    assign add_result = res_r;

    typedef struct { int due; int idx; logic [15:0] sum; } exp_t;
    exp_t sb[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_on = 1'b0;
    int          ptr = 0;
    logic [15:0] mcnt = '0;
    logic [1:0]  hist = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (!rst_n) begin
                chk("rsp_in_reset", {28'd0, rsp_valid}, 32'd0);
            end else begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    checks++; failures++;
                    $display("FAIL rsp_missing: no response for req%0d due cycle %0d (now %0d)", sb[0].idx, sb[0].due, cyc);
                    void'(sb.pop_front());
                end
                if (rsp_valid != 4'b0) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rsp_unexpected at cycle %0d: rsp_valid=%b expected none", cyc, rsp_valid);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("rsp_time", cyc, e.due);
                        chk("rsp_valid", {28'd0, rsp_valid}, 32'd1 << e.idx);
                        chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.sum});
                    end
                end
            end
        end
    end

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
    endtask

    // One clock: compare combinational outputs against the model, record any issue, advance
    task automatic step();
        bit          g;
        int          gi;
        logic [15:0] ea, eb;
        exp_t        e;
        @(negedge clk);
        g = 1'b0; gi = 0;
        if (en) begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (ptr + k) % NR;
                if (!g && req_valid[j]) begin g = 1'b1; gi = j; end
            end
        end
        ea = g ? req_a[gi*16 +: 16] : 16'h0;
        eb = g ? req_b[gi*16 +: 16] : 16'h0;
        chk("req_ready", {28'd0, req_ready}, g ? (32'd1 << gi) : 32'd0);
        chk("add_a", {16'd0, add_a}, {16'd0, ea});
        chk("add_b", {16'd0, add_b}, {16'd0, eb});
        chk("busy", {31'd0, busy}, {31'd0, |hist});
        chk("issue_cnt", {16'd0, issue_cnt}, {16'd0, mcnt});
        chk("issue_cnt_w4", {28'd0, issue_cnt4}, {28'd0, mcnt[3:0]});
        if (g) begin
            e.due = cyc + 2; e.idx = gi; e.sum = fadd(ea, eb);
            sb.push_back(e);
            mcnt = mcnt + 16'd1;
            ptr  = (gi + 1) % NR;
        end
        @(posedge clk); #1;
        hist = {hist[0], g};
    endtask

    task automatic model_reset();
        sb.delete();
        ptr = 0; mcnt = '0; hist = '0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_on = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {16'd0, issue_cnt}, 32'd0);
        chk("rst_rsp", {28'd0, rsp_valid}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_add_a", {16'd0, add_a}, 32'd0);

        // Single request: 1.0 + 1.0
        en = 1'b1;
        set_ops(0, 16'h3C00, 16'h3C00);
        req_valid = 4'b0001; step();
        req_valid = 4'b0000; repeat (3) step();
        chk("single_cnt", {16'd0, issue_cnt}, 32'd1);

        // Contention between req0 and req2
        set_ops(0, 16'h4000, 16'h4000);
        set_ops(2, 16'h3C00, 16'h4000);
        req_valid = 4'b0101; repeat (6) step();
        req_valid = 4'b0000; repeat (3) step();

        // Full load
        set_ops(1, 16'h3800, 16'h3800);
        set_ops(3, 16'hC000, 16'h4000);
        req_valid = 4'b1111; repeat (8) step();
        req_valid = 4'b0000; repeat (4) step();

        // Enable gating after three issues
        req_valid = 4'b1111; repeat (3) step();
        en = 1'b0; repeat (5) step();
        en = 1'b1; req_valid = 4'b0000; step();

        // Inf + -Inf on requester 1
        set_ops(1, 16'h7C00, 16'hFC00);
        req_valid = 4'b0010; step();
        req_valid = 4'b0000; repeat (3) step();

        // Reset with operations in flight
        req_valid = 4'b1111; repeat (2) step();
        req_valid = 4'b0000; step();
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp", {28'd0, rsp_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_cnt", {16'd0, issue_cnt}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("first_after_rst", {28'd0, req_ready}, 32'd1);
        step();
        req_valid = 4'b0000; repeat (3) step();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    case ($urandom_range(0, 3))
                        0: set_ops(i, 16'h3C00, 16'h3C00);
                        1: set_ops(i, 16'h3C00, 16'h4000);
                        2: set_ops(i, 16'h7C00, 16'hFC00);
                        default: set_ops(i, 16'h3800, 16'h3800);
                    endcase
                end else begin
                    set_ops(i, 16'($urandom), 16'($urandom));
                end
            end
            req_valid = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 9) != 0);
            step();
        end
        req_valid = 4'b0000; en = 1'b1;
        repeat (4) step();
        chk("sb_drain", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
